// File: rtl/max_serializer.sv
// Frames the 4-bit running maximum onto a serial line once it has been stable:
// start, 4 data bits LSB-first, even parity, stop. Only changed values are resent.
module max_serializer #(
  parameter int unsigned STABLE_CYCLES = 8,
  parameter int unsigned BIT_CYCLES    = 4,
  parameter int unsigned COUNT_W       = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         max,
  output logic               tx,
  output logic               busy,
  output logic [COUNT_W-1:0] frame_count
);

  localparam int unsigned SW = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned BW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYCLES);
  localparam logic [BW-1:0] BIT_LAST = BW'(BIT_CYCLES - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]         state_q, state_d;
  logic [3:0]         cand_q, cand_d;
  logic [SW-1:0]      stab_q, stab_d;
  logic               sent_valid_q, sent_valid_d;
  logic [3:0]         last_sent_q, last_sent_d;
  logic [3:0]         shreg_q, shreg_d;
  logic [BW-1:0]      bit_q, bit_d;
  logic [1:0]         idx_q, idx_d;
  logic [COUNT_W-1:0] fc_q, fc_d;
  logic               tx_q, tx_d;
  logic               busy_q, busy_d;
  logic               send_req;
  logic               bit_last;

  always_comb begin
    cand_d = cand_q;
    stab_d = stab_q;
    if (max != cand_q) begin
      cand_d = max;
      stab_d = SW'(1);
    end else if (stab_q != STAB_MAX) begin
      stab_d = stab_q + SW'(1);
    end
    // Decided on the tracker's next state so the frame starts on the edge
    // that completes STABLE_CYCLES equal samples.
    send_req = (stab_d == STAB_MAX) && (!sent_valid_q || (cand_d != last_sent_q));
  end

  always_comb begin
    state_d      = state_q;
    bit_d        = bit_q;
    idx_d        = idx_q;
    shreg_d      = shreg_q;
    last_sent_d  = last_sent_q;
    sent_valid_d = sent_valid_q;
    fc_d         = fc_q;
    bit_last     = (bit_q == BIT_LAST);
    case (state_q)
      S_IDLE: begin
        if (send_req) begin
          shreg_d      = cand_d;
          last_sent_d  = cand_d;
          sent_valid_d = 1'b1;
          bit_d        = '0;
          idx_d        = '0;
          state_d      = S_START;
        end
      end
      S_START: begin
        if (bit_last) begin
          bit_d   = '0;
          idx_d   = '0;
          state_d = S_DATA;
        end else begin
          bit_d = bit_q + BW'(1);
        end
      end
      S_DATA: begin
        if (bit_last) begin
          bit_d = '0;
          if (idx_q == 2'd3) state_d = S_PARITY;
          else               idx_d   = idx_q + 2'd1;
        end else begin
          bit_d = bit_q + BW'(1);
        end
      end
      S_PARITY: begin
        if (bit_last) begin
          bit_d   = '0;
          state_d = S_STOP;
        end else begin
          bit_d = bit_q + BW'(1);
        end
      end
      S_STOP: begin
        if (bit_last) begin
          bit_d   = '0;
          fc_d    = fc_q + COUNT_W'(1);
          state_d = S_IDLE;
        end else begin
          bit_d = bit_q + BW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Line level and busy are registered from the next FSM state.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_d != S_IDLE);
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shreg_d[idx_d];
      S_PARITY: tx_d = ^shreg_d;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cand_q       <= '0;
      stab_q       <= '0;
      sent_valid_q <= 1'b0;
      last_sent_q  <= '0;
      shreg_q      <= '0;
      bit_q        <= '0;
      idx_q        <= '0;
      fc_q         <= '0;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cand_q       <= cand_d;
      stab_q       <= stab_d;
      sent_valid_q <= sent_valid_d;
      last_sent_q  <= last_sent_d;
      shreg_q      <= shreg_d;
      bit_q        <= bit_d;
      idx_q        <= idx_d;
      fc_q         <= fc_d;
      tx_q         <= tx_d;
      busy_q       <= busy_d;
    end
  end

  assign tx          = tx_q;
  assign busy        = busy_q;
  assign frame_count = fc_q;

endmodule

// File: tb/tb_max_serializer.sv
// Directed bench for max_serializer: stability latency, framing, suppression of
// repeats, mid-frame changes, mid-frame reset and frame counter wrap.
module tb_max_serializer;
  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] max;
  logic       tx, busy, tx2, busy2;
  logic [7:0] fc;
  logic [1:0] fc2;
  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  max_serializer #(.STABLE_CYCLES(8), .BIT_CYCLES(4), .COUNT_W(8)) dut (
    .clk(clk), .reset(reset), .max(max), .tx(tx), .busy(busy), .frame_count(fc)
  );

  max_serializer #(.STABLE_CYCLES(8), .BIT_CYCLES(4), .COUNT_W(2)) dut_w2 (
    .clk(clk), .reset(reset), .max(max), .tx(tx2), .busy(busy2), .frame_count(fc2)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Value first sampled at the next edge; line must fall after the 8th edge.
  task automatic expect_start(input string tag);
    tick(7);
    check({tag, "_still_idle"}, 32'(tx), 32'd1);
    tick(1);
    check({tag, "_start_fall"}, 32'(tx), 32'd0);
  endtask

  // Entered just after the edge that drove the start bit.
  task automatic check_frame(input string tag, input logic [3:0] v);
    logic [6:0] bits;
    bits = {1'b1, ^v, v, 1'b0};
    for (int c = 0; c < 28; c++) begin
      check($sformatf("%s_tx%0d", tag, c), 32'(tx), 32'(bits[c / 4]));
      check($sformatf("%s_busy%0d", tag, c), 32'(busy), 32'd1);
      tick(1);
    end
    check({tag, "_end_busy"}, 32'(busy), 32'd0);
    check({tag, "_end_tx"}, 32'(tx), 32'd1);
  endtask

  initial begin
    logic [3:0] vals [5];
    logic [1:0] fc2_exp [5];
    vals    = '{4'hA, 4'hC, 4'h1, 4'h2, 4'h8};
    fc2_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    // 1: reset, then first stable value (0) is always sent
    reset = 1'b0;
    max   = 4'h0;
    tick(3);
    reset = 1'b1;
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_fc", 32'(fc), 32'd0);
    expect_start("t1");
    check_frame("t1", 4'h0);
    check("t1_fc", 32'(fc), 32'd1);

    // 2: 0xB -> 0,1,1,0,1,1,1
    max = 4'hB;
    expect_start("t2");
    check_frame("t2", 4'hB);
    check("t2_fc", 32'(fc), 32'd2);

    // 3: short excursion returning to the last sent value sends nothing
    max = 4'h5;
    tick(3);
    max = 4'hB;
    for (int i = 0; i < 20; i++) begin
      check($sformatf("t3_tx%0d", i), 32'(tx), 32'd1);
      check($sformatf("t3_busy%0d", i), 32'(busy), 32'd0);
      tick(1);
    end
    check("t3_fc", 32'(fc), 32'd2);

    // 4: change to 9 during the frame for 3; 9 follows after one idle clock
    max = 4'h3;
    expect_start("t4a");
    max = 4'h9;
    check_frame("t4a", 4'h3);
    check("t4a_fc", 32'(fc), 32'd3);
    tick(1);
    check("t4b_fall", 32'(tx), 32'd0);
    check_frame("t4b", 4'h9);
    check("t4b_fc", 32'(fc), 32'd4);

    // 5: reset during the 2nd data bit, then the stable value is resent
    max = 4'h6;
    expect_start("t5");
    tick(9);
    check("t5_data1", 32'(tx), 32'd1);
    reset = 1'b0;
    tick(1);
    check("t5_rst_tx", 32'(tx), 32'd1);
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_fc", 32'(fc), 32'd0);
    reset = 1'b1;
    expect_start("t5r");
    check_frame("t5r", 4'h6);
    check("t5r_fc", 32'(fc), 32'd1);

    // 6: narrow counter wraps 1,2,3,0,1
    reset = 1'b0;
    tick(2);
    reset = 1'b1;
    check("t6_rst_fc2", 32'(fc2), 32'd0);
    for (int n = 0; n < 5; n++) begin
      max = vals[n];
      expect_start($sformatf("t6v%0d", n));
      check_frame($sformatf("t6v%0d", n), vals[n]);
      check($sformatf("t6_fc%0d", n), 32'(fc), 32'(n + 1));
      check($sformatf("t6_fc2_%0d", n), 32'(fc2), 32'(fc2_exp[n]));
      check($sformatf("t6_tx2_%0d", n), 32'(tx2), 32'd1);
      check($sformatf("t6_busy2_%0d", n), 32'(busy2), 32'd0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
